// File: rtl/svsd_hex_driver.sv
// svsd_hex_driver: two-stage display pipeline from six BCD digit exports to
// active-low seven-segment HEX0..HEX5, with per-digit blink, decimal points
// and lamp test. Stage 1 registers the raw inputs. Stage 2 registers the
// decoded segment patterns. A free-running counter sets the blink phase.

// One display digit: decode, apply priority, register the pattern.
module svsd_hex_lane #(
  parameter bit BLANK_INVALID = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit,
  input  logic       dp,
  input  logic       blink_en,
  input  logic       lamp_test,
  input  logic       blink_phase,
  output logic [7:0] hex
);
  logic [6:0] seg;
  logic [7:0] hex_d, hex_q;

  // BCD to active-low g..a; codes 10-15 are blank or a dash.
  always_comb begin
    case (digit)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = BLANK_INVALID ? 7'h7F : 7'h3F;
    endcase
  end

  // Lamp test beats blink; blink blanks the dp too.
  always_comb begin
    hex_d = {~dp, seg};
    if (lamp_test)
      hex_d = 8'h00;
    else if (blink_phase && blink_en)
      hex_d = 8'hFF;
  end

  // Stage-2 output register; all segments off in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hex_q <= 8'hFF;
    else        hex_q <= hex_d;
  end

  assign hex = hex_q;
endmodule

// Top: input stage, blink timebase, six decode lanes.
module svsd_hex_driver #(
  parameter int unsigned CLK_HZ        = 50000000,
  parameter int unsigned BLINK_HZ      = 2,
  parameter int unsigned BLANK_INVALID = 1
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  input  logic [3:0] digit4,
  input  logic [3:0] digit5,
  input  logic [5:0] dp_in,
  input  logic [5:0] blink_mask,
  input  logic       lamp_test,
  output logic [7:0] hex0,
  output logic [7:0] hex1,
  output logic [7:0] hex2,
  output logic [7:0] hex3,
  output logic [7:0] hex4,
  output logic [7:0] hex5,
  output logic       blink_phase
);
  localparam int NUM_LANES = 6;
  localparam int unsigned HALF_RAW = CLK_HZ / (2 * BLINK_HZ);
  localparam int unsigned HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
  localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(HALF - 1);

  logic [NUM_LANES-1:0][3:0] digit_d, digit_q;
  logic [NUM_LANES-1:0]      dp_d, dp_q;
  logic [NUM_LANES-1:0]      mask_d, mask_q;
  logic                      lamp_d, lamp_q;
  logic [CW-1:0]             cnt_d, cnt_q;
  logic                      phase_d, phase_q;
  logic [NUM_LANES-1:0][7:0] hex_all;

  // Stage-1 next state: sample every input every cycle, no handshake.
  always_comb begin
    digit_d = {digit5, digit4, digit3, digit2, digit1, digit0};
    dp_d    = dp_in;
    mask_d  = blink_mask;
    lamp_d  = lamp_test;
  end

  // Stage-1 input registers.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      digit_q <= '0;
      dp_q    <= '0;
      mask_q  <= '0;
      lamp_q  <= 1'b0;
    end else begin
      digit_q <= digit_d;
      dp_q    <= dp_d;
      mask_q  <= mask_d;
      lamp_q  <= lamp_d;
    end
  end

  // Blink timebase: wrap at HALF-1 and flip the phase on the wrap.
  always_comb begin
    cnt_d   = cnt_q + CW'(1);
    phase_d = phase_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  // Blink counter and phase registers.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  // Lanes see the registered phase, so a toggle shows one cycle later.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    svsd_hex_lane #(
      .BLANK_INVALID (BLANK_INVALID != 0)
    ) u_lane (
      .clk         (clk_clk),
      .rst_n       (reset_reset_n),
      .digit       (digit_q[i]),
      .dp          (dp_q[i]),
      .blink_en    (mask_q[i]),
      .lamp_test   (lamp_q),
      .blink_phase (phase_q),
      .hex         (hex_all[i])
    );
  end

  assign hex0        = hex_all[0];
  assign hex1        = hex_all[1];
  assign hex2        = hex_all[2];
  assign hex3        = hex_all[3];
  assign hex4        = hex_all[4];
  assign hex5        = hex_all[5];
  assign blink_phase = phase_q;
endmodule
